// File: rtl/seg7_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_scan: multiplexed 7-seg driver with frame-synchronous commit,       |
// | anti-ghost blanking; optional leading-zero blanking via SEG7_LZB_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seg7_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0]         PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]         BLANK_END = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic                  DP_OFF    = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [NUM_DIGITS-1:0]   lzb_mask;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0:    hex_glyph = 7'b0111111;
      4'h1:    hex_glyph = 7'b0000110;
      4'h2:    hex_glyph = 7'b1011011;
      4'h3:    hex_glyph = 7'b1001111;
      4'h4:    hex_glyph = 7'b1100110;
      4'h5:    hex_glyph = 7'b1101101;
      4'h6:    hex_glyph = 7'b1111101;
      4'h7:    hex_glyph = 7'b0000111;
      4'h8:    hex_glyph = 7'b1111111;
      4'h9:    hex_glyph = 7'b1101111;
      4'hA:    hex_glyph = 7'b1110111;
      4'hB:    hex_glyph = 7'b1111100;
      4'hC:    hex_glyph = 7'b0111001;
      4'hD:    hex_glyph = 7'b1011110;
      4'hE:    hex_glyph = 7'b1111001;
      default: hex_glyph = 7'b1110001;
    endcase
  endfunction

  // A load on the wrap cycle bypasses the shadow so the new frame shows it at once.
  always_comb begin
    slot_end     = (pcnt_q == PCNT_LAST);
    frame_end    = slot_end && (idx_q == IDX_LAST);
    pcnt_d       = slot_end ? '0 : pcnt_q + 1'b1;
    idx_d        = idx_q;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end
    shadow_d     = load ? digits_in : shadow_q;
    shadow_dp_d  = load ? dp_in : shadow_dp_q;
    disp_d       = frame_end ? shadow_d : disp_q;
    disp_dp_d    = frame_end ? shadow_dp_d : disp_dp_q;
    frame_done_d = frame_end;
  end

`ifdef SEG7_LZB_EN
  logic lzb_lead;

  always_comb begin
    lzb_lead = 1'b1;
    lzb_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (lzb_lead && (disp_q[4*k +: 4] == 4'd0) && !disp_dp_q[k]) begin
        lzb_mask[k] = 1'b1;
      end else begin
        lzb_lead = 1'b0;
      end
    end
  end
`else
  assign lzb_mask = '0;
`endif

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_digit = disp_q[4*k +: 4];
        cur_dp    = disp_dp_q[k];
        cur_blank = lzb_mask[k];
        an_sel[k] = (pcnt_q >= BLANK_END);
      end
    end
    an_d  = an_sel ^ AN_OFF;
    seg_d = (cur_blank ? 7'd0 : hex_glyph(cur_digit)) ^ SEG_OFF;
    dp_d  = (cur_dp & ~cur_blank) ^ DP_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// tb_seg7_scan: random and directed stimulus against a cycle-count based
// display model (frame position derived from edges since reset release).
module tb_seg7_scan;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int FR = ND * SD;
`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // model state
  int          n;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_disp_dp, m_shadow_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_fd;
  logic [6:0]  glyph [16];

  seg7_scan #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic drive_cycle(input logic ld, input logic [15:0] d, input logic [3:0] p);
    int pos, slot;
    logic [3:0] dig;
    logic blank;
    load = ld; digits_in = d; dp_in = p;
    @(posedge clk);
    if (rst) begin
      n = 0; m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
    end else begin
      pos   = n % FR;
      slot  = pos / SD;
      dig   = 4'(m_disp >> (4 * slot));
      blank = LZB && (slot != 0) && ((m_disp >> (4 * slot)) == 0) && ((m_disp_dp >> slot) == 0);
      exp_an  = ((pos % SD) < BC) ? 4'hF : ~(4'(1) << slot);
      exp_seg = ~(blank ? 7'h00 : glyph[dig]);
      exp_dp  = ~(blank ? 1'b0 : m_disp_dp[slot]);
      exp_fd  = (pos == FR - 1);
      if (pos == FR - 1) begin
        m_disp    = ld ? d : m_shadow;
        m_disp_dp = ld ? p : m_shadow_dp;
      end
      if (ld) begin
        m_shadow = d; m_shadow_dp = p;
      end
      n++;
    end
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 16'($urandom), 4'($urandom));
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got an=%b seg=%b dp=%b fd=%b, want an=1111 seg=1111111 dp=1 fd=0",
                 an, seg, dp, frame_done);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (frame_done !== (i % 16 == 0)) begin
        errors++;
        $display("FAIL reset_fd_period: cycle %0d after release got fd=%b want %b",
                 i, frame_done, (i % 16 == 0));
      end
      checks++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        errors++;
        $display("FAIL reset_idle: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                 an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_scan;
    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];
    int t;
    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_tab = '{~7'b0000110, ~7'b1011011, ~7'b1001111, ~7'b1100110};
    drive_cycle(1'b1, 16'h4321, 4'h0);
    t = 0;
    while (!frame_done && t < 40) begin
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      t++;
    end
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL scan_wait_fd: got fd=%b want 1 within 40 cycles", frame_done);
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (an !== ((i % 4 == 0) ? 4'hF : an_tab[i/4]) || seg !== seg_tab[i/4] || dp !== 1'b1) begin
        errors++;
        $display("FAIL scan_slot: step %0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=1",
                 i, an, seg, dp, (i % 4 == 0) ? 4'hF : an_tab[i/4], seg_tab[i/4]);
      end
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL scan_fd: step %0d got fd=%b want %b", i, frame_done, exp_fd);
      end
    end
  endtask

  task automatic test_tear_free;
    logic [6:0] old_tab [4];
    int t;
    old_tab = '{~7'b0000110, ~7'b1011011, ~7'b1001111, ~7'b1100110};
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 16'($urandom), 4'($urandom));
    drive_cycle(1'b1, 16'h1111, 4'h0);
    t = 0;
    while (!frame_done && t < 40) begin
      checks++;
      if (seg !== old_tab[((n - 1) % FR) / SD]) begin
        errors++;
        $display("FAIL tear_old: got seg=%b want %b", seg, old_tab[((n - 1) % FR) / SD]);
      end
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      t++;
    end
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL tear_wait_fd: got fd=%b want 1 within 40 cycles", frame_done);
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (seg !== ~7'b0000110 || {an, dp, frame_done} !== {exp_an, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL tear_new: step %0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, exp_an, ~7'b0000110, exp_dp, exp_fd);
      end
    end
  endtask

  task automatic test_simultaneous;
    logic [6:0] sim_tab [4];
    int t;
    sim_tab = '{~7'b1011110, ~7'b0111001, ~7'b1111100, ~7'b1110111};
    t = 0;
    while ((n % FR) != FR - 1 && t < 40) begin
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      t++;
    end
    drive_cycle(1'b1, 16'hABCD, 4'h0);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL simul_fd: got fd=%b want 1", frame_done);
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (seg !== sim_tab[i/4] || {an, dp, frame_done} !== {exp_an, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL simul_glyph: step %0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, exp_an, sim_tab[i/4], exp_dp, exp_fd);
      end
    end
  endtask

  task automatic test_reset_mid;
    int t;
    t = 0;
    while ((n % FR) != 2 * SD && t < 40) begin
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      t++;
    end
    drive_cycle(1'b1, 16'h9999, 4'h0);
    drive_cycle(1'b0, 16'($urandom), 4'($urandom));
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_hold: got an=%b seg=%b dp=%b fd=%b want 1111 1111111 1 0",
                 an, seg, dp, frame_done);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b0, 16'($urandom), 4'($urandom));
      checks++;
      if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL rstmid_model: cycle %0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      end
      if (i == 2) begin
        checks++;
        if (an !== 4'b1110 || seg !== ~7'b0111111) begin
          errors++;
          $display("FAIL rstmid_digit0: got an=%b seg=%b want an=1110 seg=%b", an, seg, ~7'b0111111);
        end
      end
    end
  endtask

  task automatic test_lzb;
    logic [15:0] vals [2];
    logic [3:0]  dps [2];
    int t;
    vals = '{16'h0050, 16'h0000};
    dps  = '{4'b0000, 4'b0100};
    for (int v = 0; v < 2; v++) begin
      drive_cycle(1'b1, vals[v], dps[v]);
      t = 0;
      while (!frame_done && t < 40) begin
        drive_cycle(1'b0, 16'($urandom), 4'($urandom));
        t++;
      end
      checks++;
      if (!frame_done) begin
        errors++;
        $display("FAIL lzb_wait_fd: got fd=%b want 1 within 40 cycles", frame_done);
      end
      for (int i = 0; i < 16; i++) begin
        drive_cycle(1'b0, 16'($urandom), 4'($urandom));
        checks++;
        if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
          errors++;
          $display("FAIL lzb_model: value %h step %0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                   vals[v], i, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] d;
    for (int i = 0; i < 400; i++) begin
      d = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
      rst = ($urandom_range(0, 199) == 0);
      drive_cycle($urandom_range(0, 5) == 0, d, 4'($urandom) & 4'($urandom));
      checks++;
      if ({an, seg, dp, frame_done} !== {exp_an, exp_seg, exp_dp, exp_fd}) begin
        errors++;
        $display("FAIL random: iter %0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
                 i, an, seg, dp, frame_done, exp_an, exp_seg, exp_dp, exp_fd);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    n = 0;
    test_reset();
    test_scan();
    test_tear_free();
    test_simultaneous();
    test_reset_mid();
    test_lzb();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
